// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types and defaults for the coherence bus arbiter.
package coh_bus_pkg;

  localparam int unsigned DEFAULT_NUM_CORES      = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PROC_OWN  = 2'd1,
    SNOOP_OWN = 2'd2,
    INV_WAIT  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/coherence_bus_arbiter_if.sv
// Bus-side signal bundle between the arbiter (master) and the cache wrappers (slave).
interface coherence_bus_arbiter_if
  import coh_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES = DEFAULT_NUM_CORES,
  parameter int unsigned CORE_ID_W = $clog2(NUM_CORES)
);

  logic [NUM_CORES-1:0] Com_Bus_Req_proc;
  logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
  logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
  logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
  logic                 Invalidate;
  logic [NUM_CORES-1:0] Invalidation_done;
  logic                 All_Invalidation_done;
  logic [NUM_CORES-1:0] Shared_local;
  logic                 Shared;
  logic [CORE_ID_W-1:0] Bus_owner;
  logic                 Bus_busy;
  logic                 Bus_timeout;

  modport master (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done, Shared_local,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
           Bus_owner, Bus_busy, Bus_timeout
  );

  modport slave (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidate, Invalidation_done, Shared_local,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
           Bus_owner, Bus_busy, Bus_timeout
  );

endinterface

// File: rtl/coherence_bus_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after i_ptr, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_c,
  output logic [PTR_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  always_comb begin
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    o_gnt_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_valid_c      = 1'b1;
        o_gnt_c[w_idx] = 1'b1;
        o_idx_c        = w_idx;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Coherence bus arbiter: round-robin proc ownership, nested snoop grants, invalidate/shared aggregation.
// Optional watchdog enabled by defining COHERENCE_BUS_TIMEOUT_EN.
module coherence_bus_arbiter
  import coh_bus_pkg::*;
#(
  parameter int unsigned NUM_CORES      = DEFAULT_NUM_CORES,
  parameter int unsigned CORE_ID_W      = $clog2(NUM_CORES),
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                     clk,
  input logic                     rst_n,
  coherence_bus_arbiter_if.master bus
);

  if (NUM_CORES < 2 || NUM_CORES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("coherence_bus_arbiter: NUM_CORES must be 2..16 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e           r_state, w_state_nx;
  logic [NUM_CORES-1:0] r_gnt_proc, w_gnt_proc_nx;
  logic [NUM_CORES-1:0] r_gnt_snoop, w_gnt_snoop_nx;
  logic [CORE_ID_W-1:0] r_owner, w_owner_nx;
  logic [CORE_ID_W-1:0] r_rr_ptr, w_rr_ptr_nx;
  logic                 r_busy, w_busy_nx;
  logic                 r_aid, w_aid_nx;

  logic [NUM_CORES-1:0] w_pick_gnt, w_snoop_req, w_snoop_pick;
  logic [CORE_ID_W-1:0] w_pick_idx, w_ptr_after_owner;
  logic                 w_pick_valid, w_owner_req, w_all_ack, w_timeout_hit;

  rr_picker #(.N(NUM_CORES), .PTR_W(CORE_ID_W)) u_proc_pick (
    .i_req     (bus.Com_Bus_Req_proc),
    .i_ptr     (r_rr_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  // Owner identity is carried by the one-hot proc grant, so it doubles as the owner mask.
  assign w_owner_req       = |(bus.Com_Bus_Req_proc & r_gnt_proc);
  assign w_snoop_req       = bus.Com_Bus_Req_snoop & ~r_gnt_proc;
  assign w_snoop_pick      = w_snoop_req & (~w_snoop_req + NUM_CORES'(1));
  assign w_all_ack         = &(bus.Invalidation_done | r_gnt_proc);
  assign w_ptr_after_owner = (r_owner == CORE_ID_W'(NUM_CORES - 1)) ? '0 : r_owner + CORE_ID_W'(1);

  always_comb begin
    w_state_nx     = r_state;
    w_gnt_proc_nx  = r_gnt_proc;
    w_gnt_snoop_nx = r_gnt_snoop;
    w_owner_nx     = r_owner;
    w_rr_ptr_nx    = r_rr_ptr;
    w_busy_nx      = r_busy;
    w_aid_nx       = r_aid;
    if (w_timeout_hit) begin
      w_state_nx     = IDLE;
      w_gnt_proc_nx  = '0;
      w_gnt_snoop_nx = '0;
      w_busy_nx      = 1'b0;
      w_aid_nx       = 1'b0;
      w_rr_ptr_nx    = w_ptr_after_owner;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            w_state_nx    = PROC_OWN;
            w_gnt_proc_nx = w_pick_gnt;
            w_owner_nx    = w_pick_idx;
            w_busy_nx     = 1'b1;
          end
        end
        PROC_OWN: begin
          if (!w_owner_req) begin
            w_state_nx    = IDLE;
            w_gnt_proc_nx = '0;
            w_busy_nx     = 1'b0;
            w_rr_ptr_nx   = w_ptr_after_owner;
          end else if (|w_snoop_req) begin
            w_state_nx     = SNOOP_OWN;
            w_gnt_snoop_nx = w_snoop_pick;
          end else if (bus.Invalidate) begin
            w_state_nx = INV_WAIT;
          end
        end
        SNOOP_OWN: begin
          if (!(|(bus.Com_Bus_Req_snoop & r_gnt_snoop))) begin
            w_state_nx     = PROC_OWN;
            w_gnt_snoop_nx = '0;
          end
        end
        INV_WAIT: begin
          if (!bus.Invalidate) begin
            w_state_nx = PROC_OWN;
            w_aid_nx   = 1'b0;
          end else if (w_all_ack) begin
            w_aid_nx = 1'b1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt_proc  <= '0;
      r_gnt_snoop <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= 1'b0;
      r_aid       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_gnt_proc  <= w_gnt_proc_nx;
      r_gnt_snoop <= w_gnt_snoop_nx;
      r_owner     <= w_owner_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_busy      <= w_busy_nx;
      r_aid       <= w_aid_nx;
    end
  end

`ifdef COHERENCE_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout;

  assign w_timeout_hit = (r_state != IDLE) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts busy cycles; cleared while idle and on the forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= (r_state == IDLE || w_timeout_hit) ? '0 : r_wd_cnt + CNT_W'(1);
      r_timeout <= w_timeout_hit;
    end
  end

  assign bus.Bus_timeout = r_timeout;
`else
  assign w_timeout_hit   = 1'b0;
  assign bus.Bus_timeout = 1'b0;
`endif

  assign bus.Com_Bus_Gnt_proc      = r_gnt_proc;
  assign bus.Com_Bus_Gnt_snoop     = r_gnt_snoop;
  assign bus.Bus_owner             = r_owner;
  assign bus.Bus_busy              = r_busy;
  assign bus.All_Invalidation_done = r_aid;
  assign bus.Shared                = r_busy & (|(bus.Shared_local & ~r_gnt_proc));

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_coherence_bus_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;
  localparam int unsigned T = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  coherence_bus_arbiter_if #(.NUM_CORES(N), .CORE_ID_W(W)) bus ();

  coherence_bus_arbiter #(.NUM_CORES(N), .CORE_ID_W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] gp;
    logic [N-1:0] gs;
    logic [W-1:0] own;
    logic         busy;
    logic         aid;
    logic         to;
    logic         sh;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: who owns the bus, who holds the snoop slot, invalidate phase.
  int m_owner = -1;
  int m_snoop = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_inv   = 1'b0;
  bit m_aid   = 1'b0;
  bit m_to    = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_snoop = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_inv   = 1'b0;
    m_aid   = 1'b0;
    m_to    = 1'b0;
  endfunction

  function automatic bit all_acked();
    bit ok = 1'b1;
    for (int j = 0; j < N; j++)
      if (j != m_owner && !bus.Invalidation_done[j]) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_step();
    bit found;
    m_to = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_owner < 0) begin
      m_cnt = 0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && bus.Com_Bus_Req_proc[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          found   = 1'b1;
        end
      end
      return;
    end
`ifdef COHERENCE_BUS_TIMEOUT_EN
    if (m_cnt == T - 1) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_snoop = -1;
      m_inv   = 1'b0;
      m_aid   = 1'b0;
      m_to    = 1'b1;
      m_cnt   = 0;
      return;
    end
`endif
    m_cnt++;
    if (m_snoop >= 0) begin
      if (!bus.Com_Bus_Req_snoop[m_snoop]) m_snoop = -1;
    end else if (m_inv) begin
      if (!bus.Invalidate) begin
        m_inv = 1'b0;
        m_aid = 1'b0;
      end else if (all_acked()) begin
        m_aid = 1'b1;
      end
    end else if (!bus.Com_Bus_Req_proc[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (!found && j != m_owner && bus.Com_Bus_Req_snoop[j]) begin
          m_snoop = j;
          found   = 1'b1;
        end
      end
      if (!found && bus.Invalidate) m_inv = 1'b1;
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.gp   = '0;
    e.gs   = '0;
    e.own  = '0;
    e.sh   = 1'b0;
    e.busy = (m_owner >= 0);
    e.aid  = m_aid;
    e.to   = m_to;
    if (m_owner >= 0) begin
      e.gp[m_owner] = 1'b1;
      e.own         = W'(m_owner);
      for (int j = 0; j < N; j++)
        if (j != m_owner && bus.Shared_local[j]) e.sh = 1'b1;
    end
    if (m_snoop >= 0) e.gs[m_snoop] = 1'b1;
    return e;
  endfunction

  // One bus cycle: advance the model on the edge, then drive new inputs and queue the expectation.
  task automatic cycle(input logic [N-1:0] rp, input logic [N-1:0] rs, input logic inv,
                       input logic [N-1:0] idn, input logic [N-1:0] sl, input logic rv);
    logic was_up;
    @(posedge clk);
    model_step();
    #1;
    was_up                 = rst_n;
    bus.Com_Bus_Req_proc   = rp;
    bus.Com_Bus_Req_snoop  = rs;
    bus.Invalidate         = inv;
    bus.Invalidation_done  = idn;
    bus.Shared_local       = sl;
    rst_n                  = rv;
    if (!rv) model_reset();
    exp_q.push_back(expected());
    if (was_up && !rv) begin
      #1;
      chk("rst_gnt_proc",  32'(bus.Com_Bus_Gnt_proc),      32'h0);
      chk("rst_gnt_snoop", 32'(bus.Com_Bus_Gnt_snoop),     32'h0);
      chk("rst_busy",      32'(bus.Bus_busy),              32'h0);
      chk("rst_owner",     32'(bus.Bus_owner),             32'h0);
      chk("rst_all_inv",   32'(bus.All_Invalidation_done), 32'h0);
      chk("rst_timeout",   32'(bus.Bus_timeout),           32'h0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt_proc",  32'(bus.Com_Bus_Gnt_proc),      32'(e.gp));
        chk("gnt_snoop", 32'(bus.Com_Bus_Gnt_snoop),     32'(e.gs));
        chk("bus_busy",  32'(bus.Bus_busy),              32'(e.busy));
        if (e.busy) chk("bus_owner", 32'(bus.Bus_owner), 32'(e.own));
        chk("all_inv",   32'(bus.All_Invalidation_done), 32'(e.aid));
        chk("timeout",   32'(bus.Bus_timeout),           32'(e.to));
        chk("shared",    32'(bus.Shared),                32'(e.sh));
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] rp, rs, idn, sl;
    logic         inv;
    bus.Com_Bus_Req_proc  = '0;
    bus.Com_Bus_Req_snoop = '0;
    bus.Invalidate        = 1'b0;
    bus.Invalidation_done = '0;
    bus.Shared_local      = '0;

    repeat (3) cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("reset_gnt_proc", 32'(bus.Com_Bus_Gnt_proc), 32'h0);

    // Two requesters: core 1 first from pointer 0, then core 2 after release.
    cycle(4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("tp1_gnt_core1", 32'(bus.Com_Bus_Gnt_proc), 32'h2);
    chk("tp1_owner1", 32'(bus.Bus_owner), 32'h1);
    cycle(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("tp1_idle_gap", 32'(bus.Com_Bus_Gnt_proc), 32'h0);
    cycle(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("tp1_gnt_core2", 32'(bus.Com_Bus_Gnt_proc), 32'h4);

    // Owner 2 with nested snoop grants to cores 0 then 3.
    cycle(4'b0100, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("tp3_snoop0", 32'(bus.Com_Bus_Gnt_snoop), 32'h1);
    chk("tp3_proc_held", 32'(bus.Com_Bus_Gnt_proc), 32'h4);
    cycle(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0100, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    #1 chk("tp3_snoop3", 32'(bus.Com_Bus_Gnt_snoop), 32'h8);
    cycle(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);

    // Owner 0 invalidation: partial acks, then all non-owners, then Invalidate drops.
    cycle(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1);
    repeat (2) cycle(4'b0001, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1);
    #1 chk("tp4_partial", 32'(bus.All_Invalidation_done), 32'h0);
    cycle(4'b0001, 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b1, 4'b1110, 4'b0000, 1'b1);
    #1 chk("tp4_all_done", 32'(bus.All_Invalidation_done), 32'h1);
    cycle(4'b0001, 4'b0000, 1'b0, 4'b1110, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b0, 4'b1110, 4'b0000, 1'b1);
    #1 chk("tp4_cleared", 32'(bus.All_Invalidation_done), 32'h0);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);

    // Owner 3: its own Shared_local is masked.
    cycle(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1);
    cycle(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1);
    #1 chk("tp5_shared_masked", 32'(bus.Shared), 32'h0);
    cycle(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b1001, 1'b1);
    #1 chk("tp5_shared_other", 32'(bus.Shared), 32'h1);
    repeat (3) cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);

    // Long hold (watchdog case when enabled), then reset mid-grant.
    repeat (22) cycle(4'b0011, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);
    cycle(4'b0011, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1);

    rp = '0; rs = '0; idn = '0; sl = '0; inv = 1'b0;
    repeat (2500) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 4) == 0) rp[j] = ~rp[j];
        if ($urandom_range(0, 5) == 0) rs[j] = ~rs[j];
      end
      if ($urandom_range(0, 3) == 0) inv = ~inv;
      idn = N'($urandom) | N'($urandom);
      sl  = N'($urandom);
      cycle(rp, rs, inv, idn, sl, ($urandom_range(0, 399) != 0));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
